microwave_ctrl: RTL and testbench

MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

---
 rtl/microwave_pkg.sv | 6 +
 rtl/tick_prescaler.sv | 16 +
 rtl/microwave_ctrl.sv | 90 +++++++++
 tb/tb_microwave_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding and timing defaults for the microwave controller.
package microwave_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    localparam int TICK_DIV_DEF = 100;
    localparam int BEEP_TICKS_DEF = 3;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while run is high, one-cycle tick on the last count.
module tick_prescaler import microwave_pkg::*; #(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = run & (cnt == W'(TICK_DIV - 1));
    always_ff @(posedge clk or posedge clr)
        if (clr) cnt <= '0;
        else     cnt <= (!run || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/microwave_ctrl.sv
// microwave_ctrl: cook/pause/done sequencer driving a cascaded digit down-counter,
// magnetron and buzzer from edge-detected front-panel buttons.
module microwave_ctrl import microwave_pkg::*; #(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int BEEP_TICKS = BEEP_TICKS_DEF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    input  logic       keypad_load,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_en,
    output logic       loadn,
    output logic       data_zero,
    output logic       mag_on,
    output logic       beep,
    output logic [1:0] state
);
    localparam int BW = BEEP_TICKS > 1 ? $clog2(BEEP_TICKS) : 1;
    state_t        st;
    logic [2:0]    prev;
    logic          armed;
    logic          load_q;
    logic          dz_q;
    logic [BW-1:0] bcnt;
    logic          tick;
    logic          run;
    logic          leave;
    logic          start_p, stop_p, clear_p;
    // armed stays low for the first edge after reset so a button held through reset is not a press
    assign {start_p, stop_p, clear_p} = {start_btn, stop_btn, clear_btn} & ~prev & {3{armed}};
    // the prescaler restarts from zero whenever COOK or DONE is about to be left
    assign leave = (st == COOK && (timer_zero || clear_p || stop_p || !door_closed))
                || (st == DONE && (start_p || stop_p || clear_p || !door_closed));
    assign run = (st == COOK || st == DONE) && !leave;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (.clk(clk), .clr(clr), .run(run), .tick(tick));

    assign state     = st;
    assign timer_en  = load_q | (st == COOK && tick);
    assign loadn     = ~load_q;
    assign data_zero = dz_q;
    assign mag_on    = (st == COOK) & door_closed;
    assign beep      = (st == DONE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st     <= IDLE;
            prev   <= '0;
            armed  <= 1'b0;
            load_q <= 1'b0;
            dz_q   <= 1'b0;
            bcnt   <= '0;
        end else begin
            prev   <= {start_btn, stop_btn, clear_btn};
            armed  <= 1'b1;
            load_q <= 1'b0;
            dz_q   <= 1'b0;
            case (st)
                IDLE:
                    if (clear_p) begin
                        load_q <= 1'b1;
                        dz_q   <= 1'b1;
                    end else if (keypad_load) load_q <= 1'b1;
                    else if (start_p && door_closed && !timer_zero) st <= COOK;
                COOK:
                    if (timer_zero) st <= DONE;
                    else if (clear_p) begin
                        load_q <= 1'b1;
                        dz_q   <= 1'b1;
                        st     <= IDLE;
                    end else if (stop_p || !door_closed) st <= PAUSE;
                PAUSE:
                    if (clear_p) begin
                        load_q <= 1'b1;
                        dz_q   <= 1'b1;
                        st     <= IDLE;
                    end else if (start_p && door_closed) st <= COOK;
                DONE:
                    if (leave || (tick && bcnt == BW'(BEEP_TICKS - 1))) begin
                        st   <= IDLE;
                        bcnt <= '0;
                    end else if (tick) bcnt <= bcnt + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed stimulus pushes expected outputs into a queue;
// a negedge monitor pops and compares them against the DUT.
module tb_microwave_ctrl;
    import microwave_pkg::*;

    logic clk = 1'b0;
    logic clr, start_btn, stop_btn, clear_btn, keypad_load, door_closed, timer_zero;
    logic timer_en, loadn, data_zero, mag_on, beep;
    logic [1:0] state;

    microwave_ctrl #(.TICK_DIV(4), .BEEP_TICKS(2)) dut (
        .clk(clk), .clr(clr), .start_btn(start_btn), .stop_btn(stop_btn),
        .clear_btn(clear_btn), .keypad_load(keypad_load), .door_closed(door_closed),
        .timer_zero(timer_zero), .timer_en(timer_en), .loadn(loadn),
        .data_zero(data_zero), .mag_on(mag_on), .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] M_ST = 7'b1100000, M_TE = 7'b0010000, M_LN = 7'b0001000;
    localparam logic [6:0] M_DZ = 7'b0000100, M_MG = 7'b0000010, M_BP = 7'b0000001;
    localparam logic [6:0] M_ALL = 7'b1111111;

    typedef struct {
        string      n;
        logic [6:0] m;
        logic [6:0] e;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] v(logic [1:0] s, logic te, logic ln, logic dz, logic mg, logic bp);
        return {s, te, ln, dz, mg, bp};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string n, logic [6:0] m, logic [6:0] e);
        exp_t x;
        x.n = n;
        x.m = m;
        x.e = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        logic [6:0] o;
        exp_t x;
        o = {state, timer_en, loadn, data_zero, mag_on, beep};
        while (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if ((o & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL %s: got %b want %b (mask %b) at %0t", x.n, o & x.m, x.e & x.m, x.m, $time);
            end
        end
    end

    initial begin
        clr = 1; start_btn = 0; stop_btn = 0; clear_btn = 0;
        keypad_load = 0; door_closed = 1; timer_zero = 0;
        cyc(); chk("rst", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); clr = 0; chk("rst_rel", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc();
        // keypad load pulse
        cyc(); keypad_load = 1; chk("kp_pre", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); keypad_load = 0; chk("kp_pulse", M_ALL, v(IDLE, 1, 0, 0, 0, 0));
        cyc(); chk("kp_end", M_TE | M_LN | M_DZ, v(IDLE, 0, 1, 0, 0, 0));
        // start and tick every 4th cycle
        cyc(); start_btn = 1; chk("st_pre", M_ST, v(IDLE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 0;
        for (int i = 0; i < 8; i++) begin
            chk("cook_tick", M_ST | M_TE | M_LN | M_MG, v(COOK, (i % 4) == 3, 1, 0, 1, 0));
            cyc();
        end
        // finish and beep
        timer_zero = 1; chk("tz_cook", M_ST, v(COOK, 0, 0, 0, 0, 0));
        cyc(); timer_zero = 0;
        for (int i = 0; i < 8; i++) begin
            chk("done_beep", M_ALL, v(DONE, 0, 1, 0, 0, 1));
            cyc();
        end
        chk("done_end", M_ST | M_BP, v(IDLE, 0, 0, 0, 0, 0));
        // door opening
        start_btn = 1;
        cyc(); start_btn = 0; chk("door_cook", M_ST | M_MG, v(COOK, 0, 0, 0, 1, 0));
        cyc(); door_closed = 0; chk("door_mag", M_ST | M_MG, v(COOK, 0, 0, 0, 0, 0));
        cyc(); chk("door_pause", M_ST | M_MG, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 1; chk("door_open_st", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 0; chk("door_open_ign", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); door_closed = 1; chk("door_shut", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 1; chk("resume_pre", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 0; chk("resume", M_ST | M_MG, v(COOK, 0, 0, 0, 1, 0));
        // clear from COOK
        cyc(); clear_btn = 1; chk("clr_cook", M_ST, v(COOK, 0, 0, 0, 0, 0));
        cyc(); clear_btn = 0; chk("clr_pulse", M_ALL, v(IDLE, 1, 0, 1, 0, 0));
        cyc(); chk("clr_end", M_TE | M_LN | M_DZ, v(IDLE, 0, 1, 0, 0, 0));
        // clear and keypad coincide
        cyc(); clear_btn = 1; keypad_load = 1; chk("ck_pre", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); clear_btn = 0; keypad_load = 0; chk("ck_pulse", M_ALL, v(IDLE, 1, 0, 1, 0, 0));
        cyc(); chk("ck_once", M_TE | M_LN | M_DZ, v(IDLE, 0, 1, 0, 0, 0));
        // timer_zero beats stop
        cyc(); start_btn = 1;
        cyc(); start_btn = 0; chk("pr_cook", M_ST, v(COOK, 0, 0, 0, 0, 0));
        cyc(); timer_zero = 1; stop_btn = 1; chk("pr_pre", M_ST, v(COOK, 0, 0, 0, 0, 0));
        cyc(); timer_zero = 0; stop_btn = 0; chk("pr_done", M_ST | M_BP, v(DONE, 0, 0, 0, 0, 1));
        cyc(); stop_btn = 1; chk("done_press_pre", M_ST | M_BP, v(DONE, 0, 0, 0, 0, 1));
        cyc(); stop_btn = 0; chk("done_press", M_ST | M_BP, v(IDLE, 0, 0, 0, 0, 0));
        // held start gives one press
        cyc(); start_btn = 1; chk("held_idle", M_ST, v(IDLE, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            cyc(); chk("held_cook", M_ST, v(COOK, 0, 0, 0, 0, 0));
        end
        cyc(); stop_btn = 1; chk("held_stop", M_ST, v(COOK, 0, 0, 0, 0, 0));
        cyc(); stop_btn = 0; chk("held_pause", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); chk("held_pause", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); chk("held_pause", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 0; chk("held_pause", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        cyc(); chk("held_pause", M_ST, v(PAUSE, 0, 0, 0, 0, 0));
        // async reset mid-COOK with start held through reset
        cyc(); start_btn = 1;
        cyc(); start_btn = 0; chk("pre_clr", M_ST | M_MG, v(COOK, 0, 0, 0, 1, 0));
        cyc(); clr = 1; start_btn = 1; chk("clr_async", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); chk("clr_hold", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); clr = 0; chk("clr_rel", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); chk("held_rst1", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        cyc(); chk("held_rst2", M_ST, v(IDLE, 0, 0, 0, 0, 0));
        cyc(); start_btn = 0; chk("held_rst3", M_ALL, v(IDLE, 0, 1, 0, 0, 0));
        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
